crc_frame_serializer: RTL and testbench
=======================================

// Module: crc_frame_serializer
// PURPOSE
//  Upstream feeder for the serial CRC engine. Accepts a frame of DATA_LENGTH bytes over a
//  valid/ready byte interface, then drives it bit-serially on Ser_Data with Ser_Active high
//  for exactly DATA_LENGTH*8 cycles. It then waits for the CRC engine's Valid phase (CRC_WIDTH
//  cycles) to finish before accepting the next frame, so the CRC engine never sees overlapping frames.
// PARAMETERS
//  DATA_LENGTH  1   frame length in bytes (>=1)
//  CRC_WIDTH    8   number of cycles CRC_Valid is expected high per frame
//  CRC_TIMEOUT  16  max cycles to wait in WAIT_CRC for CRC_Valid to rise (>=1)
// PORTS
//  CLK         in   1   system clock; all logic on rising edge
//  RST_n       in   1   synchronous, active-low reset
//  In_Data     in   8   frame byte; byte 0 is sent first
//  In_Valid    in   1   In_Data is valid
//  In_Ready    out  1   block can accept a byte this cycle
//  Ser_Data    out  1   serial bit to CRC engine Data input
//  Ser_Active  out  1   to CRC engine Active input; high only while frame bits are driven
//  CRC_Valid   in   1   Valid output of the CRC engine
//  Busy        out  1   high in any state other than IDLE
//  Frame_Done  out  1   1-cycle pulse: CRC phase completed normally
//  Err         out  1   1-cycle pulse: CRC timeout or early CRC_Valid drop
// BEHAVIOUR
//  - Reset (RST_n=0 at a clock edge): state=IDLE; In_Ready=0 on that cycle; Ser_Data=0;
//    Ser_Active=0; Busy=0; Frame_Done=0; Err=0; byte buffer, byte index and counters cleared.
//    This applies mid-frame as well: any partial frame is discarded and no Err is raised.
//  - All outputs are registered except In_Ready, which is decoded from state (In_Ready=1 in
//    IDLE/LOAD).
//  - FSM:
//    IDLE     In_Ready=1. A handshake (In_Valid&&In_Ready) stores byte 0 -> LOAD. If
//             DATA_LENGTH==1 -> SHIFT instead.
//    LOAD     Stores bytes 1..DATA_LENGTH-1 on handshakes. After the last byte -> SHIFT.
//             A cycle with In_Valid=0 holds the state (no timeout).
//    SHIFT    In_Ready=0; In_Valid is ignored. Ser_Active=1 from the first cycle after the
//             last handshake, for exactly DATA_LENGTH*8 consecutive cycles.
//             Bit order: byte 0 first; within each byte, LSB first (default).
//             After the final bit, Ser_Active=0 and Ser_Data=0 on the next cycle -> WAIT_CRC.
//    WAIT_CRC Timeout counter starts at 0 on entry.
//             - If CRC_Valid is not seen within CRC_TIMEOUT cycles: Err pulse -> IDLE.
//             - Once CRC_Valid=1, count consecutive high cycles. On reaching CRC_WIDTH:
//               Frame_Done pulse -> IDLE.
//             - If CRC_Valid drops before CRC_WIDTH cycles: Err pulse -> IDLE.
//  - Frame_Done and Err are never high in the same cycle.
//  - The earliest new handshake is the cycle after the Frame_Done/Err pulse.
//  - Counter widths: bit counter $clog2(DATA_LENGTH*8+1); timeout counter $clog2(CRC_TIMEOUT+1);
//    CRC counter $clog2(CRC_WIDTH+1). None of the counters wrap.
//  - CRC_Valid is ignored outside WAIT_CRC.
// CONFIGURATION
//  SER_MSB_FIRST_EN defined: bits within each byte are sent MSB first (byte order unchanged).
//  SER_MSB_FIRST_EN undefined: bits within each byte are sent LSB first, matching the CRC engine's
//  default bit ordering.
// TESTING
//  1. DATA_LENGTH=1, In_Data=0x93 -> Ser_Active high for 8 cycles; Ser_Data=1,1,0,0,1,0,0,1;
//     with CRC_Valid held high 8 cycles -> exactly one Frame_Done pulse, Busy falls.
//  2. Same as test 1 with SER_MSB_FIRST_EN defined -> Ser_Data=1,0,0,1,0,0,1,1.
//  3. DATA_LENGTH=2, bytes 0x01 then 0x80 with a 3-cycle In_Valid gap between them
//     -> 16 Active cycles; Ser_Data=1,0x7,0x7,1 (1, seven 0s, seven 0s, 1).
//  4. CRC_Valid never asserted -> Err pulse exactly CRC_TIMEOUT cycles after WAIT_CRC entry;
//     In_Ready=1 on the next cycle.
//  5. CRC_Valid high 5 of 8 cycles, then low -> Err pulse on the cycle after the drop;
//     no Frame_Done.
//  6. RST_n=0 at the 4th SHIFT cycle -> Ser_Active=0 the next cycle; the next frame
//     (0xA5) serializes cleanly from bit 0.

Source files
------------

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: buffers a DATA_LENGTH-byte frame and streams it bit-serially to the CRC engine, then waits out its Valid phase.
// Define SER_MSB_FIRST_EN to send bits within each byte MSB first (default LSB first).
module crc_frame_serializer #(
  parameter int DATA_LENGTH = 1,
  parameter int CRC_WIDTH   = 8,
  parameter int CRC_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [7:0] In_Data,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic       Ser_Data,
  output logic       Ser_Active,
  input  logic       CRC_Valid,
  output logic       Busy,
  output logic       Frame_Done,
  output logic       Err
);
  localparam int W  = DATA_LENGTH * 8;
  localparam int BW = $clog2(W + 1);
  localparam int TW = $clog2(CRC_TIMEOUT + 1);
  localparam int CW = $clog2(CRC_WIDTH + 1);
  localparam int IW = DATA_LENGTH > 1 ? $clog2(DATA_LENGTH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAIT_CRC} state_t;
  state_t state;
  logic [W-1:0] frame_q, frame_n;
  logic [IW-1:0] idx;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [CW-1:0] crc_cnt;
  logic [7:0] ord;
  logic hs, last;
  assign In_Ready = RST_n && (state == IDLE || state == LOAD);
  assign hs = In_Valid && In_Ready;
  assign last = idx == IW'(DATA_LENGTH - 1);
`ifdef SER_MSB_FIRST_EN
  assign ord = {In_Data[0], In_Data[1], In_Data[2], In_Data[3], In_Data[4], In_Data[5], In_Data[6], In_Data[7]};
`else
  assign ord = In_Data;
`endif
  // Bytes are pre-ordered so serialization is always a plain LSB-first shift
  always_comb begin
    frame_n = frame_q;
    for (int i = 0; i < DATA_LENGTH; i++)
      if (idx == IW'(i)) frame_n[8*i +: 8] = ord;
  end
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state      <= IDLE;
      frame_q    <= '0;
      idx        <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      crc_cnt    <= '0;
      Ser_Data   <= 1'b0;
      Ser_Active <= 1'b0;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
      Err        <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: if (hs) begin
          Busy <= 1'b1;
          if (last) begin
            state      <= SHIFT;
            Ser_Active <= 1'b1;
            Ser_Data   <= frame_n[0];
            frame_q    <= frame_n >> 1;
            bit_cnt    <= BW'(1);
            idx        <= '0;
          end else begin
            state   <= LOAD;
            frame_q <= frame_n;
            idx     <= idx + 1'b1;
          end
        end
        SHIFT: if (bit_cnt == BW'(W)) begin
          state      <= WAIT_CRC;
          Ser_Active <= 1'b0;
          Ser_Data   <= 1'b0;
          to_cnt     <= '0;
          crc_cnt    <= '0;
        end else begin
          Ser_Data <= frame_q[0];
          frame_q  <= frame_q >> 1;
          bit_cnt  <= bit_cnt + 1'b1;
        end
        // Stay in WAIT_CRC during the pulse so no handshake overlaps it
        WAIT_CRC: if (Frame_Done || Err) begin
          state      <= IDLE;
          Busy       <= 1'b0;
          Frame_Done <= 1'b0;
          Err        <= 1'b0;
        end else if (CRC_Valid) begin
          crc_cnt    <= crc_cnt + 1'b1;
          Frame_Done <= crc_cnt == CW'(CRC_WIDTH - 1);
        end else if (crc_cnt != '0 || to_cnt == TW'(CRC_TIMEOUT - 1)) begin
          Err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_serializer.sv
// tb_crc_frame_serializer: randomized checks of two instances (1-byte and 2-byte frames) against a frame-level model.
module tb_crc_frame_serializer;
  localparam int CWD = 8;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] din;
  logic [1:0] iv;
  logic crc_v;
  logic [1:0] rdy, sd, act, busy, dn, er;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  crc_frame_serializer #(.DATA_LENGTH(1), .CRC_WIDTH(CWD), .CRC_TIMEOUT(TMO)) u1 (
    .CLK(clk), .RST_n(rst_n), .In_Data(din), .In_Valid(iv[0]), .In_Ready(rdy[0]),
    .Ser_Data(sd[0]), .Ser_Active(act[0]), .CRC_Valid(crc_v), .Busy(busy[0]),
    .Frame_Done(dn[0]), .Err(er[0]));
  crc_frame_serializer #(.DATA_LENGTH(2), .CRC_WIDTH(CWD), .CRC_TIMEOUT(TMO)) u2 (
    .CLK(clk), .RST_n(rst_n), .In_Data(din), .In_Valid(iv[1]), .In_Ready(rdy[1]),
    .Ser_Data(sd[1]), .Ser_Active(act[1]), .CRC_Valid(crc_v), .Busy(busy[1]),
    .Frame_Done(dn[1]), .Err(er[1]));
  function automatic logic exp_bit(input logic [7:0] b, input int i);
`ifdef SER_MSB_FIRST_EN
    return b[7-i];
`else
    return b[i];
`endif
  endfunction
  // Whole-frame scenario: s selects the instance, st<0 means CRC_Valid never rises
  task automatic run_frame(input int s, input logic [7:0] b0, input logic [7:0] b1,
                           input int gap, input int st, input int len);
    logic [7:0] bytes [2];
    int n, pulse_at;
    logic ok;
    bytes[0] = b0;
    bytes[1] = b1;
    n = s + 1;
    for (int j = 0; j < n; j++) begin
      for (int g = 0; g < (j > 0 ? gap : 0); g++) begin
        iv = 2'b00;
        din = 8'($urandom);
        @(negedge clk);
        total++;
        if (rdy[s] !== 1'b1 || busy[s] !== 1'b1 || act[s] !== 1'b0) begin
          bad++;
          $display("FAIL load_hold s=%0d rdy=%b busy=%b act=%b want 1 1 0", s, rdy[s], busy[s], act[s]);
        end
      end
      total++;
      if (rdy[s] !== 1'b1) begin
        bad++;
        $display("FAIL accept s=%0d byte=%0d rdy=%b want 1", s, j, rdy[s]);
      end
      iv = 2'b00;
      iv[s] = 1'b1;
      din = bytes[j];
      @(negedge clk);
    end
    for (int k = 0; k < 8 * n; k++) begin
      iv = 2'b00;
      iv[s] = 1'($urandom);
      din = 8'($urandom);
      crc_v = 1'($urandom);
      total++;
      if (act[s] !== 1'b1 || sd[s] !== exp_bit(bytes[k/8], k % 8) || rdy[s] !== 1'b0 || busy[s] !== 1'b1) begin
        bad++;
        $display("FAIL shift s=%0d k=%0d act=%b data=%b rdy=%b busy=%b want 1 %b 0 1",
                 s, k, act[s], sd[s], rdy[s], busy[s], exp_bit(bytes[k/8], k % 8));
      end
      @(negedge clk);
    end
    iv = 2'b00;
    total++;
    if (act[s] !== 1'b0 || sd[s] !== 1'b0 || busy[s] !== 1'b1) begin
      bad++;
      $display("FAIL shift_end s=%0d act=%b data=%b busy=%b want 0 0 1", s, act[s], sd[s], busy[s]);
    end
    ok = st >= 0 && st < TMO && len >= CWD;
    pulse_at = (st < 0 || st >= TMO) ? TMO : (len >= CWD ? st + CWD : st + len + 1);
    for (int c = 0; c <= pulse_at; c++) begin
      total++;
      if (dn[s] !== (c == pulse_at && ok) || er[s] !== (c == pulse_at && !ok) || busy[s] !== 1'b1 || rdy[s] !== 1'b0) begin
        bad++;
        $display("FAIL wait s=%0d c=%0d done=%b err=%b busy=%b rdy=%b want done=%b err=%b busy=1 rdy=0",
                 s, c, dn[s], er[s], busy[s], rdy[s], c == pulse_at && ok, c == pulse_at && !ok);
      end
      crc_v = st >= 0 && c >= st && c < st + len;
      if (c < pulse_at) @(negedge clk);
    end
    crc_v = 1'b0;
    @(negedge clk);
    total++;
    if (rdy[s] !== 1'b1 || busy[s] !== 1'b0 || dn[s] !== 1'b0 || er[s] !== 1'b0 || act[s] !== 1'b0) begin
      bad++;
      $display("FAIL after_pulse s=%0d rdy=%b busy=%b done=%b err=%b act=%b want 1 0 0 0 0",
               s, rdy[s], busy[s], dn[s], er[s], act[s]);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    iv = 2'b00;
    din = 8'h00;
    crc_v = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (rdy !== 2'b00 || sd !== 2'b00 || act !== 2'b00 || busy !== 2'b00 || dn !== 2'b00 || er !== 2'b00) begin
      bad++;
      $display("FAIL reset rdy=%b sd=%b act=%b busy=%b done=%b err=%b want all 0", rdy, sd, act, busy, dn, er);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rdy !== 2'b11 || busy !== 2'b00) begin
      bad++;
      $display("FAIL reset_release rdy=%b busy=%b want 11 00", rdy, busy);
    end
  endtask
  task automatic test_single_byte;
    run_frame(0, 8'h93, 8'h00, 0, 2, CWD);
  endtask
  task automatic test_gap;
    run_frame(1, 8'h01, 8'h80, 3, 0, CWD + 2);
  endtask
  task automatic test_timeout;
    run_frame(0, 8'($urandom), 8'h00, 0, -1, 0);
    run_frame(1, 8'($urandom), 8'($urandom), 1, TMO - 1, CWD);
    run_frame(0, 8'($urandom), 8'h00, 0, TMO, CWD);
  endtask
  task automatic test_drop;
    run_frame(0, 8'($urandom), 8'h00, 0, 0, 5);
    run_frame(1, 8'($urandom), 8'($urandom), 0, 3, CWD - 1);
  endtask
  task automatic test_mid_reset;
    iv = 2'b01;
    din = 8'($urandom);
    @(negedge clk);
    iv = 2'b00;
    repeat (3) @(negedge clk);
    total++;
    if (act[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_shift act=%b want 1", act[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (act[0] !== 1'b0 || sd[0] !== 1'b0 || busy[0] !== 1'b0 || er[0] !== 1'b0 || dn[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset act=%b data=%b busy=%b err=%b done=%b want 0 0 0 0 0", act[0], sd[0], busy[0], er[0], dn[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 8'hA5, 8'h00, 0, 1, CWD);
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      run_frame(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                r == 19 ? -1 : r, int'($urandom_range(1, 10)));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_byte();
    test_gap();
    test_timeout();
    test_drop();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
